// File: rtl/audio_pkg.sv
// Shared state type, cue width and named cue ids used by the game FSM, the cue arbiter and
// the audio player.
package audio_pkg;

   localparam int unsigned CUE_W = 3;

   typedef enum logic [1:0] {
      StIdle,
      StPlay,
      StGap
   } arb_state_e;

   localparam logic [CUE_W-1:0] CueSilence  = 3'd0;
   localparam logic [CUE_W-1:0] CueCoin     = 3'd1;
   localparam logic [CUE_W-1:0] CueJump     = 3'd2;
   localparam logic [CUE_W-1:0] CueHit      = 3'd3;
   localparam logic [CUE_W-1:0] CueLevelUp  = 3'd4;
   localparam logic [CUE_W-1:0] CuePowerUp  = 3'd5;
   localparam logic [CUE_W-1:0] CueGameOver = 3'd6;
   localparam logic [CUE_W-1:0] CueVictory  = 3'd7;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/audio_prio_enc.sv
// Combinational priority encoder: reports whether any request bit is set and the index of the
// highest set bit.
module audio_prio_enc #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   output logic            valid,
   output logic [IDW-1:0]  idx
);

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      // Ascending scan so the highest set index is the last one written.
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = IDW'(i);
         end
      end
   end

endmodule

// File: rtl/audio_cue_arbiter.sv
// Arbitrates one-shot audio cue requests onto a single player: highest index wins, top index
// may preempt, and a silent gap is enforced between cues.
module audio_cue_arbiter
   import audio_pkg::*;
#(
   parameter int unsigned NREQ           = 4,
   parameter int unsigned GAP_CYCLES     = 1000000,
   parameter int unsigned TIMEOUT_CYCLES = 400000000,
   parameter int unsigned IDW            = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [CUE_W*NREQ-1:0] cue,
   input  logic                  seq_end,
   output logic                  audio_enable,
   output logic [CUE_W-1:0]      audio_select,
   output logic [NREQ-1:0]       grant,
   output logic [IDW-1:0]        active_id,
   output logic                  busy,
   output logic                  timeout
);

   localparam int unsigned CNT_W = $clog2(max_u(GAP_CYCLES, TIMEOUT_CYCLES) + 1);

   arb_state_e       state_q, state_d;
   logic [NREQ-1:0]  pend_q, pend_d;
   logic [CUE_W-1:0] cue_q [NREQ];
   logic [CUE_W-1:0] cue_d [NREQ];
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             en_d, busy_d, to_d;
   logic [CUE_W-1:0] sel_d;
   logic [NREQ-1:0]  grant_d;
   logic [IDW-1:0]   id_d;

   logic             win_valid;
   logic [IDW-1:0]   win_idx;

   audio_prio_enc #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_prio_enc (
      .req   (pend_q),
      .valid (win_valid),
      .idx   (win_idx)
   );

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      cue_d   = cue_q;
      en_d    = audio_enable;
      sel_d   = audio_select;
      id_d    = active_id;
      grant_d = '0;
      to_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (win_valid) begin
               pend_d[win_idx]  = 1'b0;
               grant_d[win_idx] = 1'b1;
               sel_d            = cue_q[win_idx];
               id_d             = win_idx;
               en_d             = 1'b1;
               state_d          = StPlay;
            end
         end
         StPlay: begin
            // seq_end outranks preemption so a finishing cue counts as completed.
            if (seq_end) begin
               en_d    = 1'b0;
               state_d = StGap;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               en_d    = 1'b0;
               to_d    = 1'b1;
               state_d = StGap;
            end else if (pend_q[NREQ-1] && (active_id != IDW'(NREQ - 1))) begin
               en_d    = 1'b0;
               state_d = StGap;
            end
         end
         StGap: begin
            if (cnt_q >= CNT_W'(GAP_CYCLES - 1)) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // New requests are applied after the grant clear so a colliding request stays pending.
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (req[i]) begin
            pend_d[i] = 1'b1;
            cue_d[i]  = cue[CUE_W*i +: CUE_W];
         end
      end

      busy_d = (state_d != StIdle);

      if ((state_d != state_q) || (state_q == StIdle)) begin
         cnt_d = '0;
      end else if (cnt_q != {CNT_W{1'b1}}) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         pend_q       <= '0;
         cnt_q        <= '0;
         audio_enable <= 1'b0;
         audio_select <= '0;
         grant        <= '0;
         active_id    <= '0;
         busy         <= 1'b0;
         timeout      <= 1'b0;
         for (int unsigned i = 0; i < NREQ; i++) begin
            cue_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         cnt_q        <= cnt_d;
         audio_enable <= en_d;
         audio_select <= sel_d;
         grant        <= grant_d;
         active_id    <= id_d;
         busy         <= busy_d;
         timeout      <= to_d;
         for (int unsigned i = 0; i < NREQ; i++) begin
            cue_q[i] <= cue_d[i];
         end
      end
   end

endmodule

// File: tb/tb_audio_cue_arbiter.sv
// Self-checking bench for audio_cue_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural cue-scheduling model.
module tb_audio_cue_arbiter;

   localparam int N   = 4;
   localparam int GAP = 4;
   localparam int TO  = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  req = '0;
   logic [3*N-1:0] cue = '0;
   logic          seq_end = 1'b0;
   logic          audio_enable;
   logic [2:0]    audio_select;
   logic [N-1:0]  grant;
   logic [1:0]    active_id;
   logic          busy;
   logic          timeout;

   int n_vec  = 0;
   int n_miss = 0;

   audio_cue_arbiter #(
      .NREQ           (N),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .cue          (cue),
      .seq_end      (seq_end),
      .audio_enable (audio_enable),
      .audio_select (audio_select),
      .grant        (grant),
      .active_id    (active_id),
      .busy         (busy),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   // Behavioural model: a queue of pending cues, a "playing" flag with elapsed play length,
   // and a countdown of remaining silent gap cycles.
   bit         m_pend [N];
   logic [2:0] m_cue  [N];
   bit         m_play;
   int         m_len;
   int         m_gap;
   logic       e_en, e_busy, e_to;
   logic [2:0] e_sel;
   logic [N-1:0] e_grant;
   logic [1:0] e_id;

   function automatic void model_clear();
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0;
         m_cue[i]  = '0;
      end
      m_play = 0; m_len = 0; m_gap = 0;
      e_en = 0; e_busy = 0; e_to = 0; e_sel = '0; e_grant = '0; e_id = '0;
   endfunction

   function automatic void model_edge(input logic [N-1:0] r, input logic [3*N-1:0] c,
                                      input logic se);
      int win;
      bit stop;
      win = -1;
      stop = 0;
      e_grant = '0;
      e_to = 0;
      if (m_play) begin
         m_len++;
         if (se) stop = 1;
         else if (m_len == TO) begin
            stop = 1;
            e_to = 1;
         end else if (m_pend[N-1] && int'(e_id) != N-1) stop = 1;
         if (stop) begin
            m_play = 0;
            m_gap  = GAP;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else begin
         for (int i = 0; i < N; i++) if (m_pend[i]) win = i;
         if (win >= 0) begin
            m_pend[win]  = 0;
            m_play       = 1;
            m_len        = 0;
            e_sel        = m_cue[win];
            e_id         = 2'(win);
            e_grant[win] = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (r[i]) begin
            m_pend[i] = 1;
            m_cue[i]  = c[3*i +: 3];
         end
      end
      e_en   = m_play;
      e_busy = m_play || (m_gap > 0);
   endfunction

   function automatic logic [11:0] obs();
      return {audio_enable, audio_select, grant, active_id, busy, timeout};
   endfunction

   function automatic logic [11:0] expv();
      return {e_en, e_sel, e_grant, e_id, e_busy, e_to};
   endfunction

   function automatic logic [3*N-1:0] cue_at(input int i, input logic [2:0] v);
      logic [3*N-1:0] c;
      c = '0;
      c[3*i +: 3] = v;
      return c;
   endfunction

   task automatic step(input logic [N-1:0] r, input logic [3*N-1:0] c, input logic se);
      req = r; cue = c; seq_end = se;
      @(posedge clk);
      model_edge(r, c, se);
      #1;
      req = '0; cue = '0; seq_end = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      n_vec++;
      if (obs() !== 12'h000) begin
         n_miss++; $display("FAIL reset_outputs: got %h want 000", obs());
      end
      do_reset();
      step('0, '0, 0);
      n_vec++;
      if (obs() !== expv() || busy !== 1'b0) begin
         n_miss++; $display("FAIL reset_idle: got %h want %h", obs(), expv());
      end
   endtask

   task automatic test_basic();
      do_reset();
      step(4'b0010, cue_at(1, 3'd5), 0);
      n_vec++;
      if (audio_enable !== 1'b0) begin
         n_miss++; $display("FAIL basic_latency: enable got %b want 0", audio_enable);
      end
      step('0, '0, 0);
      n_vec++;
      if ({audio_enable, audio_select, grant, active_id} !== {1'b1, 3'd5, 4'b0010, 2'd1}) begin
         n_miss++; $display("FAIL basic_grant: got %h want %h", obs(), expv());
      end
      for (int k = 2; k < 6; k++) begin
         step('0, '0, 0);
         n_vec++;
         if (obs() !== expv() || audio_enable !== 1'b1) begin
            n_miss++; $display("FAIL basic_play[%0d]: got %h want %h", k, obs(), expv());
         end
      end
      step('0, '0, 1);
      for (int k = 0; k < GAP; k++) begin
         n_vec++;
         if ({audio_enable, busy} !== 2'b01) begin
            n_miss++; $display("FAIL basic_gap[%0d]: en/busy got %b%b want 01", k, audio_enable,
                               busy);
         end
         step('0, '0, 0);
      end
      n_vec++;
      if ({audio_enable, busy} !== 2'b00) begin
         n_miss++; $display("FAIL basic_idle: en/busy got %b%b want 00", audio_enable, busy);
      end
   endtask

   task automatic test_priority();
      do_reset();
      step(4'b0101, cue_at(0, 3'd2) | cue_at(2, 3'd6), 0);
      step('0, '0, 0);
      n_vec++;
      if ({grant, audio_select} !== {4'b0100, 3'd6}) begin
         n_miss++; $display("FAIL prio_first: got %h/%0d want 4/6", grant, audio_select);
      end
      step('0, '0, 1);
      for (int k = 0; k < GAP; k++) step('0, '0, 0);
      n_vec++;
      if ({busy, audio_enable} !== 2'b00) begin
         n_miss++; $display("FAIL prio_gap_end: busy/en got %b%b want 00", busy, audio_enable);
      end
      step('0, '0, 0);
      n_vec++;
      if ({grant, audio_select, audio_enable} !== {4'b0001, 3'd2, 1'b1}) begin
         n_miss++; $display("FAIL prio_second: got %h want %h", obs(), expv());
      end
   endtask

   task automatic test_preempt();
      bit regrant;
      regrant = 0;
      do_reset();
      step(4'b0100, cue_at(2, 3'd4), 0);
      step('0, '0, 0);
      step('0, '0, 0);
      step(4'b1000, cue_at(3, 3'd1), 0);
      n_vec++;
      if (audio_enable !== 1'b1) begin
         n_miss++; $display("FAIL preempt_hold: enable got %b want 1", audio_enable);
      end
      step('0, '0, 0);
      n_vec++;
      if ({audio_enable, busy, timeout} !== 3'b010) begin
         n_miss++; $display("FAIL preempt_drop: got %h want %h", obs(), expv());
      end
      for (int k = 0; k < GAP; k++) step('0, '0, 0);
      step('0, '0, 0);
      n_vec++;
      if ({grant, audio_select, active_id} !== {4'b1000, 3'd1, 2'd3}) begin
         n_miss++; $display("FAIL preempt_play: got %h want %h", obs(), expv());
      end
      for (int k = 0; k < 12; k++) begin
         step('0, '0, k == 0);
         if (grant[2]) regrant = 1;
      end
      n_vec++;
      if (regrant !== 1'b0) begin
         n_miss++; $display("FAIL preempt_discard: regrant seen %b want 0", regrant);
      end
   endtask

   task automatic test_timeout();
      int early;
      early = 0;
      do_reset();
      step(4'b0001, cue_at(0, 3'd3), 0);
      step('0, '0, 0);
      for (int k = 1; k < TO; k++) begin
         step('0, '0, 0);
         if (audio_enable !== 1'b1 || timeout !== 1'b0) early++;
      end
      n_vec++;
      if (early != 0) begin
         n_miss++; $display("FAIL timeout_early: bad cycles got %0d want 0", early);
      end
      step('0, '0, 0);
      n_vec++;
      if ({timeout, audio_enable, busy} !== 3'b101) begin
         n_miss++; $display("FAIL timeout_pulse: got %h want %h", obs(), expv());
      end
      step('0, '0, 0);
      n_vec++;
      if (timeout !== 1'b0) begin
         n_miss++; $display("FAIL timeout_one_cycle: timeout got %b want 0", timeout);
      end
      for (int k = 1; k < GAP; k++) step('0, '0, 0);
      n_vec++;
      if (busy !== 1'b0) begin
         n_miss++; $display("FAIL timeout_idle: busy got %b want 0", busy);
      end
   endtask

   task automatic test_overwrite();
      int extra;
      extra = 0;
      do_reset();
      step(4'b0001, cue_at(0, 3'd0), 0);
      step('0, '0, 0);
      step(4'b0010, cue_at(1, 3'd3), 0);
      step(4'b0010, cue_at(1, 3'd7), 0);
      step('0, '0, 1);
      for (int k = 0; k < GAP; k++) step('0, '0, 0);
      step('0, '0, 0);
      n_vec++;
      if ({grant, audio_select} !== {4'b0010, 3'd7}) begin
         n_miss++; $display("FAIL overwrite_cue: got %h want %h", obs(), expv());
      end
      step('0, '0, 1);
      for (int k = 0; k < 8; k++) begin
         step('0, '0, 0);
         if (grant !== 4'b0000) extra++;
      end
      n_vec++;
      if (extra != 0 || busy !== 1'b0) begin
         n_miss++; $display("FAIL overwrite_single: extra grants %0d busy %b want 0 0", extra,
                            busy);
      end
      step(4'b0010, cue_at(1, 3'd2), 0);
      step(4'b0010, cue_at(1, 3'd6), 0);
      n_vec++;
      if ({grant, audio_select} !== {4'b0010, 3'd2}) begin
         n_miss++; $display("FAIL collide_first: got %h want %h", obs(), expv());
      end
      step('0, '0, 1);
      for (int k = 0; k < GAP; k++) step('0, '0, 0);
      step('0, '0, 0);
      n_vec++;
      if ({grant, audio_select, audio_enable} !== {4'b0010, 3'd6, 1'b1}) begin
         n_miss++; $display("FAIL collide_second: got %h want %h", obs(), expv());
      end
   endtask

   task automatic test_reset_midplay();
      int stray;
      stray = 0;
      do_reset();
      step(4'b0100, cue_at(2, 3'd4), 0);
      step(4'b0001, cue_at(0, 3'd1), 0);
      step('0, '0, 0);
      #1;
      rst = 1'b0;
      model_clear();
      #1;
      n_vec++;
      if ({audio_enable, busy, grant} !== 6'b000000) begin
         n_miss++; $display("FAIL reset_async: en/busy/grant got %b%b%b want 000000",
                            audio_enable, busy, grant);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step('0, '0, 0);
         if (grant !== 4'b0000 || busy !== 1'b0) stray++;
      end
      n_vec++;
      if (stray != 0) begin
         n_miss++; $display("FAIL reset_pending: stray activity cycles %0d want 0", stray);
      end
      step(4'b0001, cue_at(0, 3'd5), 0);
      step('0, '0, 0);
      n_vec++;
      if ({grant, audio_select} !== {4'b0001, 3'd5}) begin
         n_miss++; $display("FAIL reset_newreq: got %h want %h", obs(), expv());
      end
   endtask

   task automatic test_random();
      logic [N-1:0]   r;
      logic [3*N-1:0] c;
      logic           se;
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 9) == 0);
         c  = 12'($urandom);
         se = ($urandom_range(0, 24) == 0);
         step(r, c, se);
         n_vec++;
         if (obs() !== expv()) begin
            n_miss++; $display("FAIL random[%0d]: got %h want %h", k, obs(), expv());
         end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_basic();
      test_priority();
      test_preempt();
      test_timeout();
      test_overwrite();
      test_reset_midplay();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/audio_cue_arbiter.md
AUDIO_CUE_ARBITER -- requirements
Module: audio_cue_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NREQ, 4, number of cue requesters; index NREQ-1 is highest priority and may preempt.
- GAP_CYCLES, 1000000, enforced silent cycles between cues (10 ms at 100 MHz).
- TIMEOUT_CYCLES, 400000000, maximum PLAY duration before forced release.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, system clock; the block's only clock.
- rst, in, 1, asynchronous active-low reset.
- req, in, NREQ, one-cycle request pulses, bit i from requester i.
- cue, in, 3*NREQ, packed cue ids; slice [3i+2:3i] belongs to requester i and is valid with req[i].
- seq_end, in, 1, one-cycle pulse from the audio player when the current sequence finishes.
- audio_enable, out, 1, audio player enable.
- audio_select, out, 3, cue id driven to the audio player.
- grant, out, NREQ, one-cycle pulse on the requester whose cue starts.
- active_id, out, clog2(NREQ), index of the requester currently playing.
- busy, out, 1, high when state is not IDLE.
- timeout, out, 1, one-cycle pulse on forced release.

Function
REQ-003 The block SHALL set pending[i] and capture cue slice i into cue_q[i] on each clock edge where req[i]=1.
REQ-004 A repeated req[i] while pending[i]=1 SHALL overwrite cue_q[i]; it SHALL NOT create a second entry.
REQ-005 The state machine SHALL have exactly three states: IDLE, PLAY and GAP.
REQ-006 In IDLE with any pending bit set, the block SHALL select the highest set index w, clear pending[w], and register the following on the same edge:
- audio_select=cue_q[w]
- active_id=w
- audio_enable=1
- grant[w] pulse
- next state PLAY
REQ-007 Latency SHALL be fixed: req sampled at edge N gives audio_enable=1 after edge N+1, provided the state is IDLE.
REQ-008 If req[w] arrives on the same edge that clears pending[w] for its grant, the set SHALL win and the new cue SHALL remain pending.
REQ-009 In PLAY, audio_enable SHALL stay 1 and audio_select SHALL stay stable until one of the following, and on exit audio_enable SHALL drop:
- seq_end=1: go to GAP.
- cycle counter reaches TIMEOUT_CYCLES-1: pulse timeout, go to GAP.
- pending[NREQ-1]=1 and active_id is not NREQ-1: preempt; discard the current cue and go to GAP.
REQ-010 If seq_end and a preempt condition occur in the same cycle, the exit SHALL count as normal completion; the preempting cue SHALL remain pending.
REQ-011 In GAP, audio_enable SHALL be 0 for exactly GAP_CYCLES cycles, then the state SHALL return to IDLE.
REQ-012 seq_end SHALL be ignored in IDLE and GAP.
REQ-013 A single counter SHALL serve both timeout and gap, with these rules:
- cleared on every state entry
- saturating, never wrapping
- width clog2(max(GAP_CYCLES, TIMEOUT_CYCLES)+1)
REQ-014 Pending requests SHALL be retained across PLAY and GAP; no request is dropped except by overwrite (REQ-004) or preemption discard (REQ-009).

Reset
REQ-015 rst=0 SHALL asynchronously force the following; outputs SHALL be registered:
- state=IDLE
- pending=0, counter=0
- audio_enable=0, audio_select=0, grant=0, active_id=0, busy=0, timeout=0
REQ-016 Reset during PLAY SHALL drop audio_enable immediately, without waiting for a clock edge.
REQ-017 After rst rises, the first arbitration SHALL occur no earlier than the second clock edge.

Structure
REQ-018 A shared package audio_pkg SHALL hold:
- the state enum (IDLE, PLAY, GAP)
- the CUE_W=3 constant
- the named cue id constants used by the game FSM and the audio player
REQ-019 One sub-module, audio_prio_enc, SHALL be used: combinational, NREQ-bit input, outputs valid and the highest set index.

Verification
REQ-020 Bench parameters SHALL be NREQ=4, GAP_CYCLES=4, TIMEOUT_CYCLES=20. The bench SHALL cover these directed scenarios:
- Basic: req[1] with cue=5 at edge 0 -> audio_enable=1, audio_select=5 and grant[1] after edge 1; seq_end at edge 6 -> enable low for exactly 4 cycles, then busy=0.
- Priority: req[0] (cue 2) and req[2] (cue 6) in the same cycle -> cue 6 plays first; cue 2 starts 1 cycle after the gap ends.
- Preemption: req[3] (cue 1) during PLAY of cue 4 -> enable drops next edge, 4-cycle gap, cue 1 plays; cue 4 is never regranted.
- Timeout: no seq_end -> timeout pulse at PLAY cycle 20, gap follows, busy returns to 0.
- Overwrite and collision: req[1] with cue 3, then req[1] with cue 7 before grant -> only cue 7 plays; req[1] coincident with its grant edge -> a second grant follows the gap.
- Reset: rst low mid-PLAY -> audio_enable=0 asynchronously, pending cleared, no grant after release until a new req.
